// File: rtl/activ_sr_feeder.sv
// activ_sr_feeder: buffers parallel activation words in a small FIFO and drives the
// activation shift register's load/shift/clear strobes so each word is presented
// LSB-first on the serial line for PA un-stalled cycles (PA+1 cycles per word).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clear                 synchronous flush of FIFO, FSM and shift register
//   in_valid/in_data      upstream activation word; in_ready = FIFO not full
//   smac_stall            SMAC side cannot consume a bit this cycle
//   sr_in_par             parallel word to the shift register (FIFO head)
//   sr_w_en/s_en/cl_en    shift-register load / shift / clear strobes
//   bit_valid, bit_idx    serial bit valid this cycle and its index (0 = LSB)
//   word_done             pulses with the last bit of a word
//   fifo_cnt, busy        FIFO occupancy; FSM active or FIFO non-empty
//   word_skip             (ACTIV_ZERO_SKIP_EN only) pulses when a zero word is dropped
//
// Optional feature: define ACTIV_ZERO_SKIP_EN to pop all-zero words without shifting them.

module activ_sr_feeder #(
  parameter int PA    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [PA-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     smac_stall,
  output logic [PA-1:0]            sr_in_par,
  output logic                     sr_w_en,
  output logic                     sr_s_en,
  output logic                     sr_cl_en,
  output logic                     bit_valid,
  output logic [$clog2(PA)-1:0]    bit_idx,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     busy
`ifdef ACTIV_ZERO_SKIP_EN
  ,
  output logic                     word_skip
`endif
);

  localparam int IW = $clog2(PA);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [PA-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full;
  logic          push, pop;
  logic [PA-1:0] head;

  // Holds in_ready low until the first edge after reset release.
  logic          rdy_q;

  state_e        state_q, state_d;
  logic [IW-1:0] bit_cnt_q, bit_cnt_d;

`ifdef ACTIV_ZERO_SKIP_EN
  logic          head_zero;
  logic          skip;
`endif

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = rdy_q & ~full;
  // A push that coincides with clear is dropped.
  assign push      = in_valid & in_ready & ~clear;

  assign sr_in_par = head;
  assign sr_cl_en  = clear;
  assign bit_idx   = bit_cnt_q;
  assign fifo_cnt  = cnt_q;
  assign busy      = (state_q != S_IDLE) | ~empty;

`ifdef ACTIV_ZERO_SKIP_EN
  assign head_zero = (head == '0);
  assign word_skip = skip;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    sr_w_en   = 1'b0;
    sr_s_en   = 1'b0;
    bit_valid = 1'b0;
    word_done = 1'b0;
`ifdef ACTIV_ZERO_SKIP_EN
    skip      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty && !smac_stall) state_d = S_LOAD;
`ifdef ACTIV_ZERO_SKIP_EN
        if (!empty && head_zero) begin
          pop     = 1'b1;
          skip    = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end

      S_LOAD: begin
        sr_w_en   = 1'b1;
        pop       = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        // A stall freezes both the counter and the register contents.
        if (!smac_stall) begin
          bit_valid = 1'b1;
          sr_s_en   = 1'b1;
          if (bit_cnt_q == IW'(PA - 1)) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            state_d   = empty ? S_IDLE : S_LOAD;
`ifdef ACTIV_ZERO_SKIP_EN
            if (!empty && head_zero) begin
              pop     = 1'b1;
              skip    = 1'b1;
              state_d = S_IDLE;
            end
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // clear overrides everything and keeps the other strobes quiet.
    if (clear) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      pop       = 1'b0;
      sr_w_en   = 1'b0;
      sr_s_en   = 1'b0;
      bit_valid = 1'b0;
      word_done = 1'b0;
`ifdef ACTIV_ZERO_SKIP_EN
      skip      = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rdy_q     <= 1'b1;
    end
  end

  // Storage is zeroed on reset so sr_in_par reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_activ_sr_feeder.sv
module tb_activ_sr_feeder;
  localparam int PA    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [PA-1:0] in_data = '0;
  logic          smac_stall = 1'b0;
  logic          in_ready;
  logic [PA-1:0] sr_in_par;
  logic          sr_w_en, sr_s_en, sr_cl_en, bit_valid, word_done, busy;
  logic [2:0]    bit_idx;
  logic [2:0]    fifo_cnt;
`ifdef ACTIV_ZERO_SKIP_EN
  logic          word_skip;
`endif

  activ_sr_feeder #(.PA(PA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .smac_stall(smac_stall), .sr_in_par(sr_in_par),
    .sr_w_en(sr_w_en), .sr_s_en(sr_s_en), .sr_cl_en(sr_cl_en),
    .bit_valid(bit_valid), .bit_idx(bit_idx), .word_done(word_done),
    .fifo_cnt(fifo_cnt), .busy(busy)
`ifdef ACTIV_ZERO_SKIP_EN
    , .word_skip(word_skip)
`endif
  );

  always #5 clk = ~clk;

  // The external shift register, driven by the DUT strobes.
  logic [PA-1:0] sr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sr <= '0;
    else if (sr_cl_en) sr <= '0;
    else if (sr_w_en)  sr <= sr_in_par;
    else if (sr_s_en)  sr <= sr >> 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: queued words, plus the word currently being serialised.
  logic [PA-1:0] mq[$];
  bit            m_load, m_act, m_rdy;
  int            m_pos;
  logic [PA-1:0] m_word;

  // Observations for the directed scenarios.
  logic [PA-1:0] cap_word;
  int            cap_n, load_cyc, done_cyc, bv_count, skip_n;
  int            done_q[$];
  bit            acc, lbv, lcl, lwd, ls;
  int            lidx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [PA-1:0] d, input logic st, input logic cl);
    bit e_rdy, e_w, e_bv, last, idle_now, e_skip, pop, push;
    int sz;
    in_valid = v; in_data = d; smac_stall = st; clear = cl;
    #2;
    sz       = mq.size();
    e_rdy    = m_rdy && (sz < DEPTH);
    e_w      = !cl && m_load;
    e_bv     = !cl && m_act && !st;
    last     = e_bv && (m_pos == PA - 1);
    idle_now = !m_load && !m_act;
    e_skip   = 1'b0;
`ifdef ACTIV_ZERO_SKIP_EN
    if (!cl && sz > 0 && (idle_now || last)) e_skip = (mq[0] == '0);
`endif
    check("in_ready", in_ready, e_rdy);
    check("fifo_cnt", fifo_cnt, sz);
    check("busy", busy, (m_load || m_act || sz > 0));
    check("sr_cl_en", sr_cl_en, cl);
    check("sr_w_en", sr_w_en, e_w);
    check("sr_s_en", sr_s_en, e_bv);
    check("bit_valid", bit_valid, e_bv);
    check("word_done", word_done, last);
    if (e_w) check("sr_in_par", sr_in_par, mq[0]);
    if (e_bv) begin
      check("bit_idx", bit_idx, m_pos);
      check("serial_bit", sr[0], m_word[m_pos]);
    end
`ifdef ACTIV_ZERO_SKIP_EN
    check("word_skip", word_skip, e_skip);
    if (word_skip) skip_n++;
`endif
    acc = v && in_ready;
    lbv = bit_valid; lidx = bit_idx; lcl = sr_cl_en; lwd = word_done; ls = sr_s_en;
    if (sr_w_en) load_cyc = cyc;
    if (bit_valid) begin cap_word[bit_idx] = sr[0]; cap_n++; bv_count++; end
    if (word_done) begin done_cyc = cyc; done_q.push_back(cyc); end

    push = v && e_rdy && !cl;
    if (cl) begin
      mq.delete(); m_load = 0; m_act = 0; m_pos = 0;
    end else begin
      pop = 0;
      if (m_load) begin
        m_word = mq[0]; pop = 1; m_load = 0; m_act = 1; m_pos = 0;
      end else if (e_skip) begin
        pop = 1; m_act = 0; m_pos = 0;
      end else if (idle_now) begin
        m_load = (sz > 0) && !st;
      end else if (e_bv) begin
        if (last) begin m_act = 0; m_pos = 0; m_load = (sz > 0); end
        else m_pos++;
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    @(posedge clk); #1;
    m_rdy = 1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; clear = 0; smac_stall = 0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {sr_w_en, sr_s_en, sr_cl_en, bit_valid, word_done, busy}, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_sr_in_par", sr_in_par, 0);
    mq.delete(); m_load = 0; m_act = 0; m_pos = 0; m_rdy = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    int c0, k, before_done, before_bv;
    #1;
    do_reset();

    // 1: single word A5, latency and bit order
    cycle(0, '0, 0, 0);
    check("ready_after_release", in_ready, 1);
    c0 = cyc; cap_n = 0;
    cycle(1, 8'hA5, 0, 0);
    repeat (12) cycle(0, '0, 0, 0);
    check("t1_load_latency", load_cyc - c0, 2);
    check("t1_bits", cap_word, 8'hA5);
    check("t1_nbits", cap_n, 8);
    check("t1_done_cycle", done_cyc - c0, 10);

    // 2: fill FIFO while stalled, fifth word waits for the first pop
    for (int i = 0; i < 4; i++) cycle(1, 8'h10 + 8'(i), 1, 0);
    check("t2_cnt_full", fifo_cnt, 4);
    check("t2_ready_full", in_ready, 0);
    done_q.delete(); c0 = cyc; acc = 0; k = 0;
    while (!acc && k < 20) begin cycle(1, 8'h14, 0, 0); k++; end
    check("t2_fifth_accepted", acc, 1);
    check("t2_fifth_wait", cyc - c0, 3);
    repeat (60) cycle(0, '0, 0, 0);
    check("t2_words", done_q.size(), 5);
    for (int i = 1; i < 5; i++)
      check("t2_spacing", (done_q.size() == 5) ? done_q[i] - done_q[i-1] : -1, 9);

    // 3: 3-cycle stall at bit 3
    cycle(1, 8'h5C, 0, 0);
    k = 0; lbv = 0;
    while (!(lbv && lidx == 2) && k < 20) begin cycle(0, '0, 0, 0); k++; end
    check("t3_reach_idx2", (lbv && lidx == 2), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 0);
      check("t3_stall_bv", lbv, 0);
      check("t3_stall_sen", ls, 0);
    end
    cycle(0, '0, 0, 0);
    check("t3_resume_idx", lidx, 3);
    repeat (10) cycle(0, '0, 0, 0);
    check("t3_done_delay", done_cyc - load_cyc, 11);

    // 4: clear at bit 5 with two words queued
    cycle(1, 8'h11, 0, 0); cycle(1, 8'h22, 0, 0); cycle(1, 8'h33, 0, 0);
    check("t4_queued", fifo_cnt, 2);
    k = 0; lbv = 0;
    while (!(lbv && lidx == 4) && k < 20) begin cycle(0, '0, 0, 0); k++; end
    check("t4_reach_idx4", (lbv && lidx == 4), 1);
    before_done = done_q.size(); before_bv = bv_count;
    cycle(1, 8'h44, 0, 1);
    check("t4_cl_en", lcl, 1);
    check("t4_no_done", lwd, 0);
    check("t4_cnt_after", fifo_cnt, 0);
    check("t4_busy_after", busy, 0);
    repeat (6) cycle(0, '0, 0, 0);
    check("t4_no_more_done", done_q.size(), before_done);
    check("t4_no_more_bits", bv_count, before_bv);

    // 5: reset mid-word
    cycle(1, 8'h77, 0, 0);
    k = 0; lbv = 0;
    while (!(lbv && lidx == 1) && k < 20) begin cycle(0, '0, 0, 0); k++; end
    #2;
    check("t5_pre_bv", bit_valid, 1);
    check("t5_pre_idx", bit_idx, 2);
    before_done = done_q.size(); before_bv = bv_count;
    do_reset();
    repeat (15) cycle(0, '0, 0, 0);
    check("t5_no_resume", bv_count, before_bv);
    check("t5_no_done", done_q.size(), before_done);

    // 6: zero word followed by 0x03
    done_q.delete(); skip_n = 0;
    cycle(1, 8'h00, 0, 0); cycle(1, 8'h03, 0, 0);
    repeat (25) cycle(0, '0, 0, 0);
`ifdef ACTIV_ZERO_SKIP_EN
    check("t6_skips", skip_n, 1);
    check("t6_words", done_q.size(), 1);
`else
    check("t6_words", done_q.size(), 2);
    check("t6_spacing", (done_q.size() == 2) ? done_q[1] - done_q[0] : -1, 9);
`endif
    check("t6_last_word", cap_word, 8'h03);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, st, cl;
      logic [PA-1:0] d;
      v  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 7) == 0) ? '0 : PA'($urandom);
      st = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 63) == 0);
      cycle(v, d, st, cl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
